// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin APB master shared by two requesters
// Optional macro APB_ARB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT wait states.
module apb_master_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic              write0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              write1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state, state_nx;
  logic                gnt, gnt_nx;
  logic                last_gnt, last_gnt_nx;
  logic [ADDR_W-1:0]   paddr_nx;
  logic                pwrite_nx, psel_nx, penable_nx;
  logic [DATA_W-1:0]   pwdata_nx;
  logic [1:0]          done_nx;
  logic [DATA_W-1:0]   rdata_nx;
  logic                err_nx;
  logic [1:0]          eligible;
  logic                pick;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt, cnt_nx;
`endif

  // A requester whose done is still high is dropping req and must not be re-granted.
  assign eligible = req & ~done;
  assign pick     = eligible[1] & (~eligible[0] | ~last_gnt);

  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    last_gnt_nx = last_gnt;
    paddr_nx    = paddr;
    pwrite_nx   = pwrite;
    psel_nx     = psel;
    penable_nx  = penable;
    pwdata_nx   = pwdata;
    done_nx     = 2'b00;
    rdata_nx    = '0;
    err_nx      = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_nx      = cnt;
`endif
    case (state)
      IDLE: begin
        paddr_nx   = '0;
        pwrite_nx  = 1'b0;
        psel_nx    = 1'b0;
        penable_nx = 1'b0;
        pwdata_nx  = '0;
        if (|eligible) begin
          gnt_nx    = pick;
          paddr_nx  = pick ? addr1  : addr0;
          pwrite_nx = pick ? write1 : write0;
          pwdata_nx = pick ? wdata1 : wdata0;
          psel_nx   = 1'b1;
          state_nx  = SETUP;
        end
      end
      SETUP: begin
        penable_nx = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_nx     = '0;
`endif
        state_nx   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          paddr_nx     = '0;
          pwrite_nx    = 1'b0;
          psel_nx      = 1'b0;
          penable_nx   = 1'b0;
          pwdata_nx    = '0;
          done_nx[gnt] = 1'b1;
          rdata_nx     = pwrite ? '0 : prdata;
          last_gnt_nx  = gnt;
          state_nx     = IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        // The wait cycle that would bring the count to TIMEOUT aborts instead.
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          paddr_nx     = '0;
          pwrite_nx    = 1'b0;
          psel_nx      = 1'b0;
          penable_nx   = 1'b0;
          pwdata_nx    = '0;
          done_nx[gnt] = 1'b1;
          err_nx       = 1'b1;
          last_gnt_nx  = gnt;
          state_nx     = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      paddr    <= '0;
      pwrite   <= 1'b0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwdata   <= '0;
      done     <= 2'b00;
      rdata    <= '0;
      err      <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      last_gnt <= last_gnt_nx;
      paddr    <= paddr_nx;
      pwrite   <= pwrite_nx;
      psel     <= psel_nx;
      penable  <= penable_nx;
      pwdata   <= pwdata_nx;
      done     <= done_nx;
      rdata    <= rdata_nx;
      err      <= err_nx;
`ifdef APB_ARB_TIMEOUT_EN
      cnt      <= cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - randomized bench for apb_master_arbiter against a transfer-level model
module tb_apb_master_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic          write0, write1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    done;
  logic [DW-1:0] rdata;
  logic          err;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;

  always #5 clk = ~clk;

  apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req),
    .write0(write0), .addr0(addr0), .wdata0(wdata0),
    .write1(write1), .addr1(addr1), .wdata1(wdata1),
    .done(done), .rdata(rdata), .err(err),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: one outstanding transfer, described by its owner,
  // its latched fields and how many cycles have passed since grant.
  logic          m_busy, m_g, m_wr, m_last;
  logic [AW-1:0] m_ad;
  logic [DW-1:0] m_wd;
  int            m_age, m_waits;
  logic [1:0]    prev_done, elig;
  logic [AW-1:0] exp_paddr;
  logic          exp_pwrite, exp_psel, exp_penable, exp_err;
  logic [DW-1:0] exp_pwdata, exp_rdata;
  logic [1:0]    exp_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_g = 0; m_wr = 0; m_last = 1; m_ad = '0; m_wd = '0;
      m_age = 0; m_waits = 0;
      exp_done = 0; exp_rdata = 0; exp_err = 0;
    end else begin
      prev_done = exp_done;
      exp_done  = 0;
      exp_rdata = 0;
      exp_err   = 0;
      if (!m_busy) begin
        elig = req & ~prev_done;
        if (elig != 2'b00) begin
          m_g    = (elig == 2'b11) ? ~m_last : elig[1];
          m_wr   = m_g ? write1 : write0;
          m_ad   = m_g ? addr1  : addr0;
          m_wd   = m_g ? wdata1 : wdata0;
          m_busy = 1;
          m_age  = 1;
        end
      end else if (m_age == 1) begin
        m_age   = 2;
        m_waits = 0;
      end else if (pready) begin
        exp_done[m_g] = 1'b1;
        exp_rdata     = m_wr ? '0 : prdata;
        m_last        = m_g;
        m_busy        = 0;
      end else begin
        m_waits++;
`ifdef APB_ARB_TIMEOUT_EN
        if (m_waits == TO) begin
          exp_done[m_g] = 1'b1;
          exp_err       = 1'b1;
          m_last        = m_g;
          m_busy        = 0;
        end
`endif
      end
    end
    exp_psel    = m_busy;
    exp_penable = m_busy && (m_age >= 2);
    exp_paddr   = m_busy ? m_ad : '0;
    exp_pwrite  = m_busy ? m_wr : 1'b0;
    exp_pwdata  = m_busy ? m_wd : '0;
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("psel",    32'(psel),    32'(exp_psel));
      chk("penable", 32'(penable), 32'(exp_penable));
      chk("paddr",   32'(paddr),   32'(exp_paddr));
      chk("pwrite",  32'(pwrite),  32'(exp_pwrite));
      chk("pwdata",  pwdata,       exp_pwdata);
      chk("done",    32'(done),    32'(exp_done));
      chk("rdata",   rdata,        exp_rdata);
      chk("err",     32'(err),     32'(exp_err));
    end
  end

  task automatic new_req(input int i);
    if (i == 0) begin
      write0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = $urandom; req[0] = 1'b1;
    end else begin
      write1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = $urandom; req[1] = 1'b1;
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] order [4];
  int n, got;

  initial begin
    rst = 1; req = 0; write0 = 0; write1 = 0; addr0 = 0; addr1 = 0;
    wdata0 = 0; wdata1 = 0; prdata = 0; pready = 0;
    repeat (2) step();
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_paddr", 32'(paddr), 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err_rdata", 32'(err) | rdata, 0);
    @(negedge clk);
    rst = 0;
    chk_en = 1;

    // single write from requester 0
    step();
    write0 = 1; addr0 = 8'h10; wdata0 = 32'hCAFE_0001; req = 2'b01; pready = 1;
    step();
    chk("w_psel1", 32'(psel), 1);
    chk("w_penable1", 32'(penable), 0);
    chk("w_paddr", 32'(paddr), 32'h10);
    chk("w_pwdata", pwdata, 32'hCAFE_0001);
    chk("w_pwrite", 32'(pwrite), 1);
    step();
    chk("w_penable2", 32'(penable), 1);
    step();
    chk("w_done", 32'(done), 32'b01);
    chk("w_err", 32'(err), 0);
    chk("w_rdata", rdata, 0);
    req = 0;
    repeat (2) step();

    // single read from requester 1 with two wait states
    write1 = 0; addr1 = 8'h24; prdata = 32'h1234_5678; pready = 0; req = 2'b10;
    repeat (4) step();
    chk("r_wait_done", 32'(done), 0);
    chk("r_wait_psel", 32'(psel), 1);
    pready = 1;
    step();
    chk("r_done", 32'(done), 32'b10);
    chk("r_rdata", rdata, 32'h1234_5678);
    req = 0;
    step();
    chk("r_rdata_clr", rdata, 0);

    // both requesting continuously: grants must alternate starting with 0
    n = 0;
    for (int k = 0; k < 4; k++) order[k] = 2'b00;
    new_req(0); new_req(1);
    for (int c = 0; c < 20; c++) begin
      step();
      if (done != 2'b00) begin
        if (n < 4) order[n] = done;
        n++;
        if (done[0]) new_req(0);
        if (done[1]) new_req(1);
      end
    end
    req = 0;
    chk("rr_0", 32'(order[0]), 32'b01);
    chk("rr_1", 32'(order[1]), 32'b10);
    chk("rr_2", 32'(order[2]), 32'b01);
    chk("rr_3", 32'(order[3]), 32'b10);
    repeat (3) step();

    // reset during ACCESS
    write0 = 0; addr0 = 8'h33; pready = 0; req = 2'b01;
    repeat (2) step();
    rst = 1;
    #1;
    chk("mr_psel", 32'(psel), 0);
    chk("mr_penable", 32'(penable), 0);
    chk("mr_paddr", 32'(paddr), 0);
    chk("mr_done", 32'(done), 0);
    @(negedge clk);
    rst = 0;
    pready = 1;
    got = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (done == 2'b01) begin got = k; break; end
    end
    chk("mr_relaunch_lat", got, 3);
    req = 0;
    repeat (2) step();

    // slave that never answers
    write1 = 1; addr1 = 8'h5A; wdata1 = 32'hDEAD_0005; pready = 0; req = 2'b10;
    got = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (done != 2'b00) begin got = k; break; end
    end
`ifdef APB_ARB_TIMEOUT_EN
    chk("to_lat", got, TO + 2);
    chk("to_done", 32'(done), 32'b10);
    chk("to_err", 32'(err), 1);
    chk("to_rdata", rdata, 0);
    req = 0;
    step();
    chk("to_idle", 32'(psel), 0);
`else
    chk("nto_nodone", got, 0);
    chk("nto_psel", 32'(psel), 1);
    pready = 1;
    step();
    chk("nto_done", 32'(done), 32'b10);
    chk("nto_err", 32'(err), 0);
    req = 0;
`endif
    repeat (2) step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      pready = ($urandom_range(0, 3) != 0);
      prdata = $urandom;
      for (int i = 0; i < 2; i++) begin
        if (done[i]) begin
          if ($urandom_range(0, 1) == 1) new_req(i);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          new_req(i);
        end
      end
      step();
    end
    req = 0;
    pready = 1;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Synthesizable APB master that shares one APB bus between two local requesters.
- Round-robin arbitration; each granted request runs as a single SETUP/ACCESS transfer with pready wait-state support.
- Sits between the unit-test drivers (or on-chip control clients) and an APB slave; its APB pin behaviour matches the team's APB master BFM: idle drives all zeros, SETUP, then ACCESS.

Parameters:
- ADDR_W, 8, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, ACCESS-phase wait-state limit; used only with APB_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  reset, asynchronous, active-high. Name follows the codebase (clk; _n suffix only for active-low resets).
- req  in  2  per-requester request; bit i is held high until done[i].
- write0  in  1  requester 0: 1 = write, 0 = read.
- addr0  in  ADDR_W  requester 0 address.
- wdata0  in  DATA_W  requester 0 write data.
- write1  in  1  requester 1: 1 = write, 0 = read.
- addr1  in  ADDR_W  requester 1 address.
- wdata1  in  DATA_W  requester 1 write data.
- done  out  2  one-cycle completion pulse, per requester.
- rdata  out  DATA_W  read data; valid while done is high.
- err  out  1  transfer aborted by timeout; valid with done.
- paddr  out  ADDR_W  APB address.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB slave ready.

Behaviour:
- Reset (async, immediate): state=IDLE. paddr, pwrite, psel, penable, pwdata, done, rdata, err = 0. last_gnt=1, so requester 0 wins the first tie.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - APB outputs are all 0.
  - Eligible requesters: req[i]=1 and done[i]=0 in the same cycle. This masks the requester that just completed and is still dropping req.
  - If any are eligible: grant one (sole requester, else the one != last_gnt). Latch its write/addr/wdata onto pwrite/paddr/pwdata, set psel=1, go to SETUP.
- SETUP: penable=1, go to ACCESS. Address, data and direction stay stable.
- ACCESS with pready=0: hold all APB outputs (wait state).
- ACCESS with pready=1:
  - psel, penable, pwrite, paddr, pwdata go to 0.
  - done[gnt]=1 for one cycle; last_gnt=gnt.
  - rdata=prdata for a read; rdata=0 for a write.
  - Go to IDLE.
- rdata and err clear to 0 on the cycle after done.
- Latency: req sampled high at edge 0 → psel high at edge 1 → penable at edge 2 → with pready=1, done at edge 3. Each extra wait state adds 1 cycle. Back-to-back transfers always have exactly one IDLE cycle (psel=0) between them.
- Requester inputs change only while req is low or after done. The arbiter uses only the values latched at grant, so later input changes do not affect the bus.
- Simultaneous req with no history after reset: requester 0 first, then requester 1.
- Reset mid-transfer: bus returns to idle immediately, no done pulse, the request is lost; requesters re-issue.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT, abort: APB outputs go to 0, done[gnt]=1, err=1, rdata=0, last_gnt updated, return to IDLE.
  - pready=1 in the same cycle the limit is reached is a normal completion (err=0).
- Undefined: no counter; err is tied to 0; ACCESS waits on pready indefinitely.

Test Plan:
- Single write, req0, addr0=8'h10, wdata0=32'hCAFE_0001, pready=1 → psel at edge 1, penable at edge 2, paddr=8'h10, pwdata=32'hCAFE_0001, pwrite=1; done=2'b01 at edge 3; err=0; rdata=0.
- Single read, req1, addr1=8'h24, prdata=32'h1234_5678, pready low for 2 ACCESS cycles → done=2'b10 at edge 5; rdata=32'h1234_5678 for that cycle only.
- req=2'b11 held with fresh requests after each done → grants alternate 0,1,0,1; exactly one psel=0 cycle between transfers; no requester is re-granted while its done is high.
- rst asserted during ACCESS → all APB outputs and done are 0 in the same cycle; after release with req0 high, a fresh transfer starts and its done arrives 3 cycles later.
- Timeout (macro defined, TIMEOUT=16): pready held 0 → done pulse with err=1 and rdata=0 after 16 wait cycles; bus idle on the next cycle.
- Same stimulus with the macro undefined → no done and psel stays high; pready=1 then completes with err=0.
